nixie_char_scanner: RTL and testbench

- Display end of the letter-grade path: takes 6-bit character codes from the grade/score logic and drives the 8-digit seven-segment (nixie) bank.
- Holds an 8-entry character register file written through a simple write port.
- Time-multiplexes the digits, one active digit at a time, and supports a per-digit blink.
- Sits between the Grade/score blocks and the board segment/anode pins.

---
 rtl/nixie_char_scanner.sv | 124 ++++++++++++
 tb/tb_nixie_char_scanner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nixie_char_scanner.sv
// rtl/nixie_char_scanner.sv - character register file and time-multiplexed seven-segment scanner
// Eight 6-bit character slots are scanned one digit at a time, with per-digit blink.
module nixie_char_scanner #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_char,
  input  logic [7:0] blink_mask,
  output logic [7:0] seg_left,
  output logic [7:0] seg_right,
  output logic [7:0] an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Patterns are {a,b,c,d,e,f,g,dp}; dp is never lit.
  function automatic logic [7:0] char_pattern(input logic [5:0] code);
    logic [7:0] p;
    case (code)
      6'd0:    p = 8'b11101110;
      6'd1:    p = 8'b00111110;
      6'd2:    p = 8'b10011100;
      6'd3:    p = 8'b01111010;
      6'd4:    p = 8'b10011110;
      6'd5:    p = 8'b10001110;
      6'd18:   p = 8'b10110110;
      6'd26:   p = 8'b11111100;
      6'd27:   p = 8'b01100000;
      6'd28:   p = 8'b11011010;
      6'd29:   p = 8'b11110010;
      6'd30:   p = 8'b01100110;
      6'd31:   p = 8'b10110110;
      6'd32:   p = 8'b10111110;
      6'd33:   p = 8'b11100000;
      6'd34:   p = 8'b11111110;
      6'd35:   p = 8'b11110110;
      6'd36:   p = 8'b00000010;
      default: p = 8'b00000000;
    endcase
    return p;
  endfunction

  logic [5:0]    char_q [8];
  logic [5:0]    char_d [8];
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          blink_phase_q, blink_phase_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_left_q, seg_left_d;
  logic [7:0]    seg_right_q, seg_right_d;
  logic [7:0]    pat;

  always_comb begin
    char_d = char_q;
    if (wr_en) begin
      char_d[wr_addr] = wr_char;
    end

    scan_cnt_d = scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end

    blink_cnt_d   = blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    // Digit select and segments come from the same idx so both flip on one edge.
    pat = char_pattern(char_q[idx_q]);
    if (blink_mask[idx_q] && blink_phase_q) begin
      pat = 8'h00;
    end
    an_d = 8'h01 << idx_q;
    if (idx_q[2]) begin
      seg_left_d  = 8'h00;
      seg_right_d = pat;
    end else begin
      seg_left_d  = pat;
      seg_right_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        char_q[i] <= 6'd63;
      end
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      idx_q         <= 3'd0;
      blink_phase_q <= 1'b0;
      an_q          <= 8'h00;
      seg_left_q    <= 8'h00;
      seg_right_q   <= 8'h00;
    end else begin
      char_q        <= char_d;
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      idx_q         <= idx_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_left_q    <= seg_left_d;
      seg_right_q   <= seg_right_d;
    end
  end

  assign an        = an_q;
  assign seg_left  = seg_left_q;
  assign seg_right = seg_right_q;

endmodule

// File: tb/tb_nixie_char_scanner.sv
// tb/tb_nixie_char_scanner.sv - scoreboard bench for nixie_char_scanner
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_nixie_char_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [5:0] wr_char = 6'd0;
  logic [7:0] blink_mask = 8'h00;
  logic [7:0] seg_left, seg_right, an;

  nixie_char_scanner #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .blink_mask (blink_mask),
    .seg_left   (seg_left),
    .seg_right  (seg_right),
    .an         (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] sl;
    logic [7:0] sr;
    string      name;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int c0 = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [7:0] a, input logic [7:0] sl,
                           input logic [7:0] sr, input string nm);
    exp_t e;
    e.cyc = c; e.an = a; e.sl = sl; e.sr = sr; e.name = nm;
    sb.push_back(e);
  endtask

  // Slot s (counted from reset release) covers edges c0+1+4s .. c0+4+4s.
  task automatic expect_slot(input int s, input logic [7:0] sl, input logic [7:0] sr,
                             input string nm);
    logic [7:0] a;
    a = 8'h01 << (s % 8);
    for (int k = 0; k < 4; k++) expect_at(c0 + 1 + 4 * s + k, a, sl, sr, nm);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    expect_at(cyc + 1, 8'h00, 8'h00, 8'h00, "reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    c0 = cyc;
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
        end else if (an !== e.an || seg_left !== e.sl || seg_right !== e.sr) begin
          errors++;
          $display("FAIL %s cyc %0d: an=%h seg_left=%h seg_right=%h, required an=%h seg_left=%h seg_right=%h",
                   e.name, cyc - c0, an, seg_left, seg_right, e.an, e.sl, e.sr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Blank scan after reset.
    do_reset();
    for (int s = 0; s < 9; s++) expect_slot(s, 8'h00, 8'h00, "blank_scan");
    wait_cyc(c0 + 36);

    // Letters.
    do_reset();
    wr(3'd0, 6'd18); wr(3'd1, 6'd0); wr(3'd2, 6'd1);
    wr(3'd5, 6'd3);  wr(3'd6, 6'd4); wr(3'd7, 6'd5);
    expect_slot(8,  8'hB6, 8'h00, "char_S");
    expect_slot(9,  8'hEE, 8'h00, "char_A");
    expect_slot(10, 8'h3E, 8'h00, "char_b");
    expect_slot(11, 8'h00, 8'h00, "char_blank3");
    expect_slot(12, 8'h00, 8'h00, "char_blank4");
    expect_slot(13, 8'h00, 8'h7A, "char_d");
    expect_slot(14, 8'h00, 8'h9E, "char_E");
    expect_slot(15, 8'h00, 8'h8E, "char_F");
    wait_cyc(c0 + 64);

    // Digits, dash and blank codes.
    do_reset();
    for (int i = 0; i < 8; i++) wr(3'(i), 6'(26 + i));
    expect_slot(8,  8'hFC, 8'h00, "digit0");
    expect_slot(9,  8'h60, 8'h00, "digit1");
    expect_slot(10, 8'hDA, 8'h00, "digit2");
    expect_slot(11, 8'hF2, 8'h00, "digit3");
    expect_slot(12, 8'h00, 8'h66, "digit4");
    expect_slot(13, 8'h00, 8'hB6, "digit5");
    expect_slot(14, 8'h00, 8'hBE, "digit6");
    expect_slot(15, 8'h00, 8'hE0, "digit7");
    wait_cyc(c0 + 64);
    wr(3'd0, 6'd34); wr(3'd1, 6'd35); wr(3'd2, 6'd36); wr(3'd3, 6'd40); wr(3'd4, 6'd63);
    expect_slot(24, 8'hFE, 8'h00, "digit8");
    expect_slot(25, 8'hF6, 8'h00, "digit9");
    expect_slot(26, 8'h02, 8'h00, "dash");
    expect_slot(27, 8'h00, 8'h00, "code40_blank");
    expect_slot(28, 8'h00, 8'h00, "code63_blank");
    expect_slot(29, 8'h00, 8'hB6, "digit5_kept");
    wait_cyc(c0 + 120);

    // Blink: with these dividers digits 0-3 always land in phase 0 and 4-7 in phase 1.
    blink_mask = 8'h11;
    do_reset();
    wr(3'd0, 6'd2); wr(3'd4, 6'd2);
    expect_slot(8,  8'h9C, 8'h00, "blink_phase0_shown");
    expect_slot(12, 8'h00, 8'h00, "blink_phase1_blank");
    wait_cyc(c0 + 64);
    blink_mask = 8'h00;
    expect_slot(16, 8'h9C, 8'h00, "unblink_left");
    expect_slot(20, 8'h00, 8'h9C, "unblink_right");
    wait_cyc(c0 + 84);

    // Write to the digit currently on display.
    do_reset();
    expect_at(c0 + 33, 8'h01, 8'h00, 8'h00, "live_wr_before");
    expect_at(c0 + 34, 8'h01, 8'h00, 8'h00, "live_wr_edgeN");
    expect_at(c0 + 35, 8'h01, 8'hFC, 8'h00, "live_wr_edgeN1");
    expect_at(c0 + 36, 8'h01, 8'hFC, 8'h00, "live_wr_hold");
    expect_slot(9, 8'h00, 8'h00, "live_wr_next");
    wait_cyc(c0 + 33);
    wr(3'd0, 6'd26);
    wait_cyc(c0 + 40);

    // Asynchronous reset in the middle of slot 6.
    do_reset();
    wr(3'd6, 6'd33); wr(3'd0, 6'd26);
    expect_slot(8, 8'hFC, 8'h00, "pre_rst_digit0");
    expect_at(c0 + 57, 8'h40, 8'h00, 8'hE0, "pre_rst_digit6");
    expect_at(c0 + 58, 8'h00, 8'h00, 8'h00, "async_rst");
    wait_cyc(c0 + 57);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    c0 = cyc;
    for (int s = 0; s < 8; s++) expect_slot(s, 8'h00, 8'h00, "post_rst_blank");
    wait_cyc(c0 + 32);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
